riscv_dmem_responder: RTL and testbench

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

---
 rtl/riscv_dmem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// riscv_dmem_responder: single-port RV32I data-memory responder with a
// valid/ready request channel and a valid/ready response channel.
// One request may be outstanding at a time.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words stored (power of two, 16..65536)
//   LATENCY     : extra wait cycles spent in ACCESS (0..7)
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   req_valid/ready : request handshake (ready only in IDLE)
//   req_we          : 1 = store, 0 = load
//   req_funct3      : RV32I load/store funct3
//   req_addr        : byte address (upper bits alias)
//   req_wdata       : right-aligned store data
//   rsp_valid/ready : response handshake
//   rsp_rdata       : extended load data, 0 for stores and faults
//   rsp_err         : illegal funct3 or (optionally) misaligned access
//
// Build option
//   DMEM_MISALIGN_CHECK_EN : when defined, misaligned halfword/word accesses
//   fault; otherwise they are silently aligned down.
//
// Timing: the accept edge moves IDLE->ACCESS; ACCESS lasts LATENCY+1 cycles
// and its final edge commits stores / reads the array; the first RESP cycle
// formats the load result, so rsp_valid rises LATENCY+2 edges after accept.

module riscv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned BW = AW + 2;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            q_we;
    logic [2:0]      q_f3;
    logic [BW-1:0]   q_addr;
    logic [31:0]     q_wdata;
    logic [31:0]     rd_word;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            illegal_c;
    logic            misalign_c;
    logic            err_c;
    logic            access_done_c;
    logic            commit_c;
    logic [3:0]      wstrb_c;
    logic [31:0]     wdata_c;
    logic [31:0]     load_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [AW-1:0]   idx_c;

    // Address bits above the array size alias and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:BW];

    // Fault decode, write-lane generation and load extension from captured request.
    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        wstrb_c    = 4'b0000;
        wdata_c    = q_wdata;
        load_c     = 32'h0;
        idx_c      = q_addr[BW-1:2];
        byte_c     = rd_word[8*q_addr[1:0] +: 8];
        half_c     = q_addr[1] ? rd_word[31:16] : rd_word[15:0];

        // Stores allow 000..010; loads forbid 011, 110, 111.
        if (q_we)
            illegal_c = q_f3[2] | (q_f3[1] & q_f3[0]);
        else
            illegal_c = (q_f3 == 3'b011) || (q_f3[2:1] == 2'b11);

`ifdef DMEM_MISALIGN_CHECK_EN
        misalign_c = ((q_f3[1:0] == 2'b01) && q_addr[0]) ||
                     ((q_f3[1:0] == 2'b10) && (q_addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif
        err_c = illegal_c | misalign_c;

        // Halfword lanes use addr[1] only and words ignore addr[1:0], which
        // is what aligns a misaligned access down when it is not faulted.
        case (q_f3[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << q_addr[1:0];
                wdata_c = {4{q_wdata[7:0]}};
            end
            2'b01: begin
                wstrb_c = q_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{q_wdata[15:0]}};
            end
            default: begin
                wstrb_c = 4'b1111;
                wdata_c = q_wdata;
            end
        endcase

        case (q_f3)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'h0, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'h0, half_c};
            3'b010:  load_c = rd_word;
            default: load_c = 32'h0;
        endcase
    end

    assign access_done_c = (state == ACCESS) && (cnt == CW'(LATENCY));
    // Reset in ACCESS must drop the store, so the write is gated by rst_n.
    assign commit_c      = rst_n && access_done_c && q_we && !err_c;

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            q_we      <= 1'b0;
            q_f3      <= 3'b000;
            q_addr    <= '0;
            q_wdata   <= 32'h0;
            rd_word   <= 32'h0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        q_we      <= req_we;
                        q_f3      <= req_funct3;
                        q_addr    <= req_addr[BW-1:0];
                        q_wdata   <= req_wdata;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (access_done_c) begin
                        rd_word <= mem[idx_c];
                        state   <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_c;
                        rsp_rdata <= (err_c || q_we) ? 32'h0 : load_c;
                    end else if (rsp_ready) begin
                        // req_ready rises only after this edge, so no
                        // request can be accepted during the handshake cycle.
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (commit_c) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_c[b])
                    mem[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder (DEPTH_WORDS=1024, LATENCY=1).
module tb_riscv_dmem_responder;

    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad   = 0;

    riscv_dmem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction; inputs are scrambled after accept to show they
    // are only sampled on the accept edge.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int k;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        check({tag, " ready_busy"}, 32'(req_ready), 32'h0);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'(LAT + 2));
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_valid"}, 32'(rsp_valid), 32'h1);
            check({tag, " hold_rdata"}, rsp_rdata, exp_rd);
            check({tag, " hold_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, " hold_ready"}, 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " done_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, " done_ready"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst rsp_err", 32'(rsp_err), 32'h0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst req_ready", 32'(req_ready), 32'h1);

        xact("sw10",   1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        xact("lw10",   1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        xact("lb13",   1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 0);
        xact("lbu13",  1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0, 0);
        xact("lh10",   1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
        xact("lhu12",  1'b0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 0);
        xact("sb11",   1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0,        1'b0, 0);
        xact("lw10b",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
        xact("lw12",   1'b0, 3'b010, 32'h12, 32'h0,        32'h0,        1'b1, 0);
`else
        xact("lw12",   1'b0, 3'b010, 32'h12, 32'h0,        32'hDEADAAEF, 1'b0, 0);
`endif
        xact("st011",  1'b1, 3'b011, 32'h10, 32'h0,        32'h0,        1'b1, 5);
        xact("lw10c",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 0);
        xact("ld110",  1'b0, 3'b110, 32'h10, 32'h0,        32'h0,        1'b1, 0);
        xact("sw14",   1'b1, 3'b010, 32'h14, 32'h11223344, 32'h0,        1'b0, 0);
        xact("sh16",   1'b1, 3'b001, 32'h16, 32'h1234ABCD, 32'h0,        1'b0, 0);
        xact("lw14",   1'b0, 3'b010, 32'h14, 32'h0,        32'hABCD3344, 1'b0, 0);
        xact("alias",  1'b0, 3'b010, 32'h1014, 32'h0,      32'hABCD3344, 1'b0, 0);
        xact("lb14",   1'b0, 3'b000, 32'h14, 32'h0,        32'h00000044, 1'b0, 0);
        xact("lh16",   1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFFABCD, 1'b0, 0);

        // Store dropped by reset while in ACCESS, across its commit edge.
        xact("sw20z",  1'b1, 3'b010, 32'h20, 32'h0,        32'h0,        1'b0, 0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstacc in_access", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rstacc rsp_valid", 32'(rsp_valid), 32'h0);
        check("rstacc rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstacc req_ready", 32'(req_ready), 32'h1);
        xact("lw20",   1'b0, 3'b010, 32'h20, 32'h0,        32'h0,        1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
